// File: rtl/tx_line_encoder.sv
// rtl/tx_line_encoder.sv - USB transmit line encoder: LSB-first serialiser with bit stuffing, NRZI and EOP.
// Bytes arrive through a 1-byte hold buffer so the next byte is ready at the boundary without an idle bit.
module tx_line_encoder #(
  parameter int LOW_SPEED = 0,
  parameter int STUFF_LEN = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  input  logic       data_last,
  output logic       data_ready,
  input  logic       bit_strobe,
  output logic       timer_en,
  output logic       timer_clr,
  output logic       dp,
  output logic       dm,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       underrun
);

  localparam int OW = $clog2(STUFF_LEN + 1);
  localparam logic [OW-1:0] STUFF_CNT = OW'(STUFF_LEN);
  localparam logic [1:0] LINE_J   = (LOW_SPEED != 0) ? 2'b01 : 2'b10;
  localparam logic [1:0] LINE_K   = ~LINE_J;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BYTE,
    S_SEND,
    S_EOP1,
    S_EOP2,
    S_EOP_J
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      line_q, line_d;
  logic [7:0]      hold_q, hold_d;
  logic            hold_last_q, hold_last_d;
  logic            hold_full_q, hold_full_d;
  logic            last_acc_q, last_acc_d;
  logic [7:0]      sreg_q, sreg_d;
  logic            sreg_last_q, sreg_last_d;
  logic [3:0]      bits_left_q, bits_left_d;
  logic [OW-1:0]   ones_q, ones_d;
  logic            tx_done_q, tx_done_d;
  logic            underrun_q, underrun_d;
  logic            emit;
  logic            emit_bit;
  logic [1:0]      line_tog;

  // Toggling only ever swaps J and K; SE0 is entered explicitly.
  assign line_tog   = (line_q == LINE_J) ? LINE_K : LINE_J;
  assign data_ready = !hold_full_q && !last_acc_q &&
                      ((state_q == S_WAIT_BYTE) || (state_q == S_SEND));
  assign timer_en   = (state_q == S_SEND) || (state_q == S_EOP1) ||
                      (state_q == S_EOP2) || (state_q == S_EOP_J);
  assign timer_clr  = !timer_en;
  assign tx_busy    = (state_q != S_IDLE);
  assign tx_done    = tx_done_q;
  assign underrun   = underrun_q;
  assign dp         = line_q[1];
  assign dm         = line_q[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      line_q      <= LINE_J;
      hold_q      <= '0;
      hold_last_q <= 1'b0;
      hold_full_q <= 1'b0;
      last_acc_q  <= 1'b0;
      sreg_q      <= '0;
      sreg_last_q <= 1'b0;
      bits_left_q <= '0;
      ones_q      <= '0;
      tx_done_q   <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      hold_q      <= hold_d;
      hold_last_q <= hold_last_d;
      hold_full_q <= hold_full_d;
      last_acc_q  <= last_acc_d;
      sreg_q      <= sreg_d;
      sreg_last_q <= sreg_last_d;
      bits_left_q <= bits_left_d;
      ones_q      <= ones_d;
      tx_done_q   <= tx_done_d;
      underrun_q  <= underrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    hold_d      = hold_q;
    hold_last_d = hold_last_q;
    hold_full_d = hold_full_q;
    last_acc_d  = last_acc_q;
    sreg_d      = sreg_q;
    sreg_last_d = sreg_last_q;
    bits_left_d = bits_left_q;
    ones_d      = ones_q;
    tx_done_d   = 1'b0;
    underrun_d  = 1'b0;
    emit        = 1'b0;
    emit_bit    = 1'b0;

    if (data_valid && data_ready) begin
      hold_d      = data_in;
      hold_last_d = data_last;
      hold_full_d = 1'b1;
      last_acc_d  = last_acc_q | data_last;
    end

    case (state_q)
      S_IDLE: begin
        line_d      = LINE_J;
        hold_full_d = 1'b0;
        last_acc_d  = 1'b0;
        if (tx_start) state_d = S_WAIT_BYTE;
      end
      S_WAIT_BYTE: begin
        if (hold_full_q) begin
          sreg_d      = hold_q;
          sreg_last_d = hold_last_q;
          bits_left_d = 4'd8;
          ones_d      = '0;
          hold_full_d = 1'b0;
          state_d     = S_SEND;
        end
      end
      S_SEND: begin
        if (bit_strobe) begin
          if (ones_q == STUFF_CNT) begin
            line_d = line_tog;
            ones_d = '0;
          end else if (bits_left_q != 4'd0) begin
            emit        = 1'b1;
            emit_bit    = sreg_q[0];
            sreg_d      = {1'b0, sreg_q[7:1]};
            bits_left_d = bits_left_q - 4'd1;
          end else if (hold_full_q) begin
            // Reload straight from the hold byte so there is no idle bit at the boundary.
            emit        = 1'b1;
            emit_bit    = hold_q[0];
            sreg_d      = {1'b0, hold_q[7:1]};
            sreg_last_d = hold_last_q;
            bits_left_d = 4'd7;
            hold_full_d = 1'b0;
          end else begin
            line_d     = LINE_SE0;
            underrun_d = !sreg_last_q;
            state_d    = S_EOP1;
          end
        end
      end
      S_EOP1: begin
        if (bit_strobe) state_d = S_EOP2;
      end
      S_EOP2: begin
        if (bit_strobe) begin
          line_d  = LINE_J;
          state_d = S_EOP_J;
        end
      end
      S_EOP_J: begin
        if (bit_strobe) begin
          tx_done_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (emit) begin
      if (!emit_bit) begin
        line_d = line_tog;
        ones_d = '0;
      end else begin
        ones_d = ones_q + OW'(1);
      end
    end
  end

endmodule

// File: tb/tb_tx_line_encoder.sv
// tb/tb_tx_line_encoder.sv - randomized bench for tx_line_encoder against a per-strobe line model.
// Drives full-speed and low-speed instances in lockstep.
module tb_tx_line_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_start;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_last;
  logic       bit_strobe;

  logic rdy0, ten0, tclr0, dp0, dm0, busy0, done0, ur0;
  logic rdy1, ten1, tclr1, dp1, dm1, busy1, done1, ur1;

  int checks   = 0;
  int failures = 0;

  logic [7:0] pkt_q[$];
  logic [3:0] exp0_q[$];
  logic [3:0] exp1_q[$];

  always #5 clk = ~clk;

  tx_line_encoder #(.LOW_SPEED(0), .STUFF_LEN(6)) u_fs (
    .clk(clk), .rst(rst), .tx_start(tx_start), .data_in(data_in),
    .data_valid(data_valid), .data_last(data_last), .data_ready(rdy0),
    .bit_strobe(bit_strobe), .timer_en(ten0), .timer_clr(tclr0),
    .dp(dp0), .dm(dm0), .tx_busy(busy0), .tx_done(done0), .underrun(ur0)
  );

  tx_line_encoder #(.LOW_SPEED(1), .STUFF_LEN(6)) u_ls (
    .clk(clk), .rst(rst), .tx_start(tx_start), .data_in(data_in),
    .data_valid(data_valid), .data_last(data_last), .data_ready(rdy1),
    .bit_strobe(bit_strobe), .timer_en(ten1), .timer_clr(tclr1),
    .dp(dp1), .dm(dm1), .tx_busy(busy1), .tx_done(done1), .underrun(ur1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Expected {dp,dm,underrun,tx_done} after each strobe, from the byte list.
  function automatic void build_exp(input bit ur);
    for (int d = 0; d < 2; d++) begin
      logic [3:0] q[$];
      logic [1:0] j;
      logic [1:0] line;
      int ones;
      j    = (d == 0) ? 2'b10 : 2'b01;
      line = j;
      ones = 0;
      foreach (pkt_q[i]) begin
        for (int b = 0; b < 8; b++) begin
          if (((pkt_q[i] >> b) & 8'd1) == 8'd0) begin
            line = ~line;
            ones = 0;
          end else begin
            ones++;
          end
          q.push_back({line, 2'b00});
          if (ones == 6) begin
            line = ~line;
            ones = 0;
            q.push_back({line, 2'b00});
          end
        end
      end
      q.push_back({2'b00, ur, 1'b0});
      q.push_back({2'b00, 2'b00});
      q.push_back({j, 2'b00});
      q.push_back({j, 2'b01});
      if (d == 0) exp0_q = q;
      else        exp1_q = q;
    end
  endfunction

  task automatic feed(input bit mark_last);
    for (int i = 0; i < pkt_q.size(); i++) begin
      int n = 0;
      @(negedge clk);
      data_in    = pkt_q[i];
      data_valid = 1'b1;
      data_last  = mark_last && (i == pkt_q.size() - 1);
      while (!rdy0 && n < 400) begin
        @(negedge clk);
        n++;
      end
      if (n >= 400) begin
        chk("feed_ready", rdy0, 1);
        break;
      end
      @(posedge clk);
    end
    @(negedge clk);
    data_valid = 1'b0;
    data_last  = 1'b0;
  endtask

  task automatic wait_timer();
    int n = 0;
    while (!ten0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("timer_run", {ten0, tclr0, ten1, tclr1}, 4'b1010);
  endtask

  task automatic strobe_run(input int period);
    wait_timer();
    for (int k = 0; k < exp0_q.size(); k++) begin
      repeat (period - 1) @(negedge clk);
      bit_strobe = 1'b1;
      if (k == 2) tx_start = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("fs_strobe%0d", k), {dp0, dm0, ur0, done0}, exp0_q[k]);
      chk($sformatf("ls_strobe%0d", k), {dp1, dm1, ur1, done1}, exp1_q[k]);
      @(negedge clk);
      bit_strobe = 1'b0;
      tx_start   = 1'b0;
    end
  endtask

  task automatic run_pkt(input bit mark_last, input int period);
    build_exp(!mark_last);
    @(negedge clk);
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    fork
      feed(mark_last);
      strobe_run(period);
    join
    @(negedge clk);
    chk("idle_fs", {busy0, dp0, dm0, rdy0, ten0}, 5'b0_10_0_0);
    chk("idle_ls", {busy1, dp1, dm1, rdy1, ten1}, 5'b0_01_0_0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_fs"}, {dp0, dm0, busy0, rdy0, done0, ur0, ten0, tclr0}, 8'b10_000001);
    chk({tag, "_ls"}, {dp1, dm1, busy1, rdy1, done1, ur1, ten1, tclr1}, 8'b01_000001);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    tx_start   = 1'b0;
    data_in    = 8'h00;
    data_valid = 1'b0;
    data_last  = 1'b0;
    bit_strobe = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    rst = 1'b0;

    pkt_q = '{8'h80};
    run_pkt(1'b1, 4);
    pkt_q = '{8'hFF, 8'hFF};
    run_pkt(1'b1, 3);
    pkt_q = '{8'h3F, 8'h01};
    run_pkt(1'b1, 5);
    pkt_q = '{8'h80};
    run_pkt(1'b0, 4);

    // Reset partway through the second byte.
    pkt_q = '{8'h80, 8'hA5};
    @(negedge clk);
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    fork
      feed(1'b0);
      begin
        wait_timer();
        repeat (11) begin
          repeat (3) @(negedge clk);
          bit_strobe = 1'b1;
          @(negedge clk);
          bit_strobe = 1'b0;
        end
      end
    join
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_state("midrst");
    @(negedge clk);
    rst = 1'b0;

    pkt_q = '{8'h80};
    run_pkt(1'b1, 4);

    for (int it = 0; it < 10; it++) begin
      int nb;
      nb    = $urandom_range(1, 4);
      pkt_q = '{8'h80};
      for (int i = 1; i < nb; i++) pkt_q.push_back(8'($urandom));
      run_pkt($urandom_range(0, 5) != 0, $urandom_range(3, 6));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
